// File: rtl/enable_pulse_gen.sv
// enable_pulse_gen: paces the downstream counter with single-cycle enable_t
// strobes at a programmable period. It supports run, stop and single-step
// operation, and a run ends by itself when the counter raises ready_signal.
module enable_pulse_gen #(
   parameter int N     = 4,
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             step,
   input  logic [DIV_W-1:0] period,
   input  logic             ready_signal,
   output logic             enable_t,
   output logic             busy,
   output logic             done,
   output logic [N-1:0]     strobe_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STEP = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
   localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
   localparam logic [N-1:0]     CNT_ONE  = {{(N-1){1'b0}}, 1'b1};
   localparam logic [N-1:0]     CNT_MAX  = {N{1'b1}};
   localparam logic [N-1:0]     CNT_ZERO = {N{1'b0}};

   state_t           state_r;
   logic [DIV_W-1:0] period_r;
   logic [DIV_W-1:0] prescaler_r;
   logic [DIV_W-1:0] period_eff_s;

   // Strobe counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [N-1:0] sat_inc(input logic [N-1:0] v);
      if (v == CNT_MAX) begin
         return v;
      end else begin
         return v + CNT_ONE;
      end
   endfunction

   // A period of zero is treated as one so the strobe rate is always defined.
   always_comb begin
      period_eff_s = period;
      if (period == DIV_ZERO) begin
         period_eff_s = DIV_ONE;
      end else begin
         period_eff_s = period;
      end
   end

   // Control FSM with prescaler; every output is registered alongside the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         period_r    <= DIV_ONE;
         prescaler_r <= DIV_ZERO;
         enable_t    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         strobe_cnt  <= CNT_ZERO;
      end else begin
         case (state_r)
            IDLE: begin
               enable_t <= 1'b0;
               done     <= 1'b0;
               if (stop) begin
                  state_r <= IDLE;
                  busy    <= 1'b0;
               end else if (start) begin
                  state_r     <= RUN;
                  busy        <= 1'b1;
                  period_r    <= period_eff_s;
                  prescaler_r <= period_eff_s - DIV_ONE;
                  strobe_cnt  <= CNT_ZERO;
               end else if (step) begin
                  state_r     <= STEP;
                  busy        <= 1'b1;
                  period_r    <= period_eff_s;
                  prescaler_r <= period_eff_s - DIV_ONE;
                  strobe_cnt  <= CNT_ZERO;
               end else begin
                  state_r <= IDLE;
                  busy    <= 1'b0;
               end
            end
            RUN: begin
               done <= 1'b0;
               if (stop) begin
                  state_r  <= IDLE;
                  busy     <= 1'b0;
                  enable_t <= 1'b0;
               end else if (ready_signal) begin
                  // Target reached: a strobe due on this cycle is dropped.
                  state_r  <= DONE;
                  busy     <= 1'b0;
                  enable_t <= 1'b0;
                  done     <= 1'b1;
               end else if (prescaler_r == DIV_ZERO) begin
                  enable_t    <= 1'b1;
                  prescaler_r <= period_r - DIV_ONE;
                  strobe_cnt  <= sat_inc(strobe_cnt);
               end else begin
                  enable_t    <= 1'b0;
                  prescaler_r <= prescaler_r - DIV_ONE;
               end
            end
            STEP: begin
               done <= 1'b0;
               if (stop) begin
                  state_r  <= IDLE;
                  busy     <= 1'b0;
                  enable_t <= 1'b0;
               end else if (prescaler_r == DIV_ZERO) begin
                  state_r    <= IDLE;
                  busy       <= 1'b0;
                  enable_t   <= 1'b1;
                  strobe_cnt <= sat_inc(strobe_cnt);
               end else begin
                  enable_t    <= 1'b0;
                  prescaler_r <= prescaler_r - DIV_ONE;
               end
            end
            DONE: begin
               state_r  <= IDLE;
               busy     <= 1'b0;
               enable_t <= 1'b0;
               done     <= 1'b0;
            end
            default: begin
               state_r  <= IDLE;
               busy     <= 1'b0;
               enable_t <= 1'b0;
               done     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_enable_pulse_gen.sv
// Directed bench for enable_pulse_gen: expected per-cycle outputs are pushed
// to a scoreboard queue as stimulus is set up, then popped and compared after
// each clock edge.
module tb_enable_pulse_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        stop;
   logic        step;
   logic [15:0] period;
   logic        ready_signal;
   logic        enable_t;
   logic        busy;
   logic        done;
   logic [3:0]  strobe_cnt;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic       en;
      logic       bsy;
      logic       dn;
      logic [3:0] cnt;
   } exp_t;

   exp_t sb[$];

   enable_pulse_gen #(.N(4), .DIV_W(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .stop         (stop),
      .step         (step),
      .period       (period),
      .ready_signal (ready_signal),
      .enable_t     (enable_t),
      .busy         (busy),
      .done         (done),
      .strobe_cnt   (strobe_cnt)
   );

   always #5 clk = ~clk;

   task automatic push(input logic en, input logic bsy, input logic dn, input int cnt);
      exp_t e;
      e.en  = en;
      e.bsy = bsy;
      e.dn  = dn;
      e.cnt = 4'(cnt);
      sb.push_back(e);
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock edge, then pop one expectation and compare all outputs.
   task automatic tick(input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, ".enable_t"},   {3'b000, enable_t}, {3'b000, e.en});
         chk({tag, ".busy"},       {3'b000, busy},     {3'b000, e.bsy});
         chk({tag, ".done"},       {3'b000, done},     {3'b000, e.dn});
         chk({tag, ".strobe_cnt"}, strobe_cnt,         e.cnt);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0;
      period = 16'd0; ready_signal = 1'b0;

      // Power-on reset
      push(1'b0, 1'b0, 1'b0, 0); tick("reset0");
      push(1'b0, 1'b0, 1'b0, 0); tick("reset1");
      rst = 1'b0;
      push(1'b0, 1'b0, 1'b0, 0); tick("idle");

      // period=4 run: strobes at cycles 4,8,12,16,20
      period = 16'd4; start = 1'b1;
      push(1'b0, 1'b1, 1'b0, 0); tick("p4_start");
      start = 1'b0;
      period = 16'd1; // ignored while busy
      for (int k = 1; k <= 20; k++) begin
         push((k % 4) == 0, 1'b1, 1'b0, k / 4);
         tick($sformatf("p4_c%0d", k));
      end

      // Reset mid-run
      rst = 1'b1;
      push(1'b0, 1'b0, 1'b0, 0); tick("midrun_rst");
      rst = 1'b0;
      push(1'b0, 1'b0, 1'b0, 0); tick("after_rst");

      // period=0 behaves as 1: strobe every cycle, count saturates at 15
      period = 16'd0; start = 1'b1;
      push(1'b0, 1'b1, 1'b0, 0); tick("p0_start");
      start = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         push(1'b1, 1'b1, 1'b0, (k > 15) ? 15 : k);
         tick($sformatf("p0_c%0d", k));
      end
      stop = 1'b1;
      push(1'b0, 1'b0, 1'b0, 15); tick("p0_stop");
      stop = 1'b0;
      push(1'b0, 1'b0, 1'b0, 15); tick("p0_hold");

      // Single step, period=3, ready_signal ignored while stepping
      period = 16'd3; step = 1'b1;
      push(1'b0, 1'b1, 1'b0, 0); tick("step_go");
      step = 1'b0; ready_signal = 1'b1;
      push(1'b0, 1'b1, 1'b0, 0); tick("step_c1");
      push(1'b0, 1'b1, 1'b0, 0); tick("step_c2");
      push(1'b1, 1'b0, 1'b0, 1); tick("step_c3");
      ready_signal = 1'b0;
      push(1'b0, 1'b0, 1'b0, 1); tick("step_c4");
      push(1'b0, 1'b0, 1'b0, 1); tick("step_c5");

      // period=2 run, ready_signal coincides with a due strobe
      period = 16'd2; start = 1'b1;
      push(1'b0, 1'b1, 1'b0, 0); tick("rdy_start");
      start = 1'b0;
      push(1'b0, 1'b1, 1'b0, 0); tick("rdy_c1");
      push(1'b1, 1'b1, 1'b0, 1); tick("rdy_c2");
      push(1'b0, 1'b1, 1'b0, 1); tick("rdy_c3");
      ready_signal = 1'b1;
      push(1'b0, 1'b0, 1'b1, 1); tick("rdy_done");
      ready_signal = 1'b0;
      push(1'b0, 1'b0, 1'b0, 1); tick("rdy_idle");
      push(1'b0, 1'b0, 1'b0, 1); tick("rdy_idle2");

      // start and stop together in IDLE: stays idle
      period = 16'd1; start = 1'b1; stop = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         push(1'b0, 1'b0, 1'b0, 1);
         tick($sformatf("startstop_c%0d", k));
      end
      start = 1'b0; stop = 1'b0;

      // start beats step: continuous strobing, not a single one
      period = 16'd1; start = 1'b1; step = 1'b1;
      push(1'b0, 1'b1, 1'b0, 0); tick("prio_go");
      start = 1'b0; step = 1'b0;
      push(1'b1, 1'b1, 1'b0, 1); tick("prio_c1");
      push(1'b1, 1'b1, 1'b0, 2); tick("prio_c2");
      stop = 1'b1;
      push(1'b0, 1'b0, 1'b0, 2); tick("prio_stop");
      stop = 1'b0;

      // Stop aborts a step with no strobe
      period = 16'd5; step = 1'b1;
      push(1'b0, 1'b1, 1'b0, 0); tick("stepabort_go");
      step = 1'b0; stop = 1'b1;
      push(1'b0, 1'b0, 1'b0, 0); tick("stepabort_stop");
      stop = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         push(1'b0, 1'b0, 1'b0, 0);
         tick($sformatf("stepabort_idle%0d", k));
      end

      total++;
      assert (sb.size() == 0) else begin
         bad++;
         $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
